// File: rtl/ad7606_pkt_pkg.sv
// Shared constants, header layout and FSM encoding for the AD7606 frame packer.
package ad7606_pkt_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned WORD_W = 128;
  localparam int unsigned MAX_CH = 8;
  localparam logic [15:0] MAGIC_DEF = 16'hA5A5;

  // Header field LSB positions inside the 128-bit word (MSB first on the wire)
  localparam int unsigned HDR_MAGIC_LSB = 112;
  localparam int unsigned HDR_FRAME_LSB = 96;
  localparam int unsigned HDR_CHNUM_LSB = 88;
  localparam int unsigned HDR_DECIM_LSB = 64;
  localparam int unsigned HDR_IDX_LSB   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] build_header(
    input logic [15:0] magic,
    input logic [15:0] frame,
    input logic [7:0]  ch_num,
    input logic [15:0] decim,
    input logic [31:0] idx
  );
    logic [WORD_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_FRAME_LSB +: 16] = frame;
    h[HDR_CHNUM_LSB +: 8]  = ch_num;
    h[HDR_DECIM_LSB +: 16] = decim;
    h[HDR_IDX_LSB   +: 32] = idx;
    return h;
  endfunction

endpackage

// File: rtl/ad7606_lane_packer.sv
// Accumulates CH_NUM-lane samples into 128-bit words, oldest sample in the low lanes.
module ad7606_lane_packer
  import ad7606_pkt_pkg::*;
#(
  parameter int unsigned CH_NUM = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      push_i,
  input  logic                      flush_i,
  input  logic [CH_NUM*LANE_W-1:0]  sample_i,
  output logic                      word_rdy_c,
  output logic [WORD_W-1:0]         word_c
);

  localparam int unsigned SW  = CH_NUM * LANE_W;
  localparam int unsigned SPW = WORD_W / SW;

  logic [WORD_W-1:0] acc_q, acc_d, merged_c;
  logic [2:0]        fill_q, fill_d;

  always_comb begin
    merged_c = acc_q;
    for (int unsigned s = 0; s < SPW; s++) begin
      if (fill_q == 3'(s)) merged_c[s*SW +: SW] = sample_i;
    end

    acc_d      = acc_q;
    fill_d     = fill_q;
    word_rdy_c = 1'b0;
    word_c     = acc_q;
    if (clear_i) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (push_i) begin
      if (fill_q == 3'(SPW - 1)) begin
        word_rdy_c = 1'b1;
        word_c     = merged_c;
        acc_d      = '0;
        fill_d     = '0;
      end else begin
        acc_d  = merged_c;
        fill_d = fill_q + 3'd1;
      end
    end else if (flush_i) begin
      // Unfilled upper lanes are already zero in the accumulator
      word_rdy_c = (fill_q != 3'd0);
      acc_d      = '0;
      fill_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/ad7606_frame_packer.sv
// Packs AD7606 channel samples into framed 128-bit FDMA write words with a header per frame.
module ad7606_frame_packer
  import ad7606_pkt_pkg::*;
#(
  parameter int unsigned CH_NUM      = 8,
  parameter int unsigned FRAME_WORDS = 256,
  parameter logic [15:0] MAGIC       = MAGIC_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [LANE_W-1:0]    ad_ch1_i,
  input  logic [LANE_W-1:0]    ad_ch2_i,
  input  logic [LANE_W-1:0]    ad_ch3_i,
  input  logic [LANE_W-1:0]    ad_ch4_i,
  input  logic [LANE_W-1:0]    ad_ch5_i,
  input  logic [LANE_W-1:0]    ad_ch6_i,
  input  logic [LANE_W-1:0]    ad_ch7_i,
  input  logic [LANE_W-1:0]    ad_ch8_i,
  input  logic                 ad_data_valid_i,
  input  logic                 cap_start_i,
  input  logic                 cap_stop_i,
  input  logic [15:0]          decim_i,
  input  logic                 fifo_full_i,
  output logic                 wr_en_o,
  output logic [WORD_W-1:0]    wr_data_o,
  output logic                 busy_o,
  output logic [15:0]          frame_cnt_o,
  output logic [15:0]          drop_cnt_o
);

  localparam int unsigned SW    = CH_NUM * LANE_W;
  localparam int unsigned CNT_W = $clog2(FRAME_WORDS);

  state_e             state_q, state_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [15:0]        dec_cnt_q, dec_cnt_d, decim_q, decim_d;
  logic [31:0]        sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic               pend_valid_q, pend_valid_d;
  logic [SW-1:0]      pend_samp_q, pend_samp_d;
  logic               wr_en_q, wr_en_d, busy_q, busy_d;
  logic [WORD_W-1:0]  wr_data_q, wr_data_d;

  logic [LANE_W-1:0]  ch_c [MAX_CH];
  logic [SW-1:0]      samp_c, pk_samp_c;
  logic               eff_valid_c, pk_clear_c, pk_push_c, pk_flush_c, pk_rdy_c, emit_c;
  logic [WORD_W-1:0]  pk_word_c, emit_word_c;

  assign ch_c = '{ad_ch1_i, ad_ch2_i, ad_ch3_i, ad_ch4_i,
                  ad_ch5_i, ad_ch6_i, ad_ch7_i, ad_ch8_i};

  always_comb begin
    samp_c = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) samp_c[i*LANE_W +: LANE_W] = ch_c[i];
  end

  // Packer control; a sample parked during HEADER/FLUSH takes the place of the live input
  always_comb begin
    pk_clear_c  = 1'b0;
    pk_push_c   = 1'b0;
    pk_flush_c  = 1'b0;
    pk_samp_c   = samp_c;
    eff_valid_c = 1'b0;
    case (state_q)
      ST_IDLE:  pk_clear_c = cap_start_i & ~cap_stop_i;
      ST_DATA: begin
        eff_valid_c = ad_data_valid_i | pend_valid_q;
        if (pend_valid_q) pk_samp_c = pend_samp_q;
        pk_push_c = eff_valid_c && (dec_cnt_q == 16'd0);
      end
      ST_FLUSH: pk_flush_c = 1'b1;
      default: ;
    endcase
  end

  ad7606_lane_packer #(.CH_NUM(CH_NUM)) u_lane_packer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (pk_clear_c),
    .push_i     (pk_push_c),
    .flush_i    (pk_flush_c),
    .sample_i   (pk_samp_c),
    .word_rdy_c (pk_rdy_c),
    .word_c     (pk_word_c)
  );

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    dec_cnt_d    = dec_cnt_q;
    decim_d      = decim_q;
    sample_idx_d = sample_idx_q;
    data_cnt_d   = data_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_samp_d  = pend_samp_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    emit_c       = 1'b0;
    emit_word_c  = pk_word_c;

    case (state_q)
      ST_IDLE: begin
        if (pk_clear_c) begin
          state_d      = ST_HEADER;
          frame_cnt_d  = '0;
          drop_cnt_d   = '0;
          dec_cnt_d    = '0;
          sample_idx_d = '0;
          data_cnt_d   = '0;
          pend_valid_d = 1'b0;
          decim_d      = decim_i;
        end
      end
      ST_HEADER: begin
        emit_c      = 1'b1;
        emit_word_c = build_header(MAGIC, frame_cnt_q, 8'(CH_NUM), decim_q, sample_idx_q);
        if (ad_data_valid_i) begin
          pend_valid_d = 1'b1;
          pend_samp_d  = samp_c;
        end
        state_d = cap_stop_i ? ST_FLUSH : ST_DATA;
      end
      ST_DATA: begin
        pend_valid_d = 1'b0;
        if (eff_valid_c) dec_cnt_d = (dec_cnt_q == decim_q) ? 16'd0 : dec_cnt_q + 16'd1;
        if (pk_push_c) sample_idx_d = sample_idx_q + 32'd1;
        if (pk_rdy_c) begin
          emit_c = 1'b1;
          if (data_cnt_q == CNT_W'(FRAME_WORDS - 2)) begin
            data_cnt_d = '0;
            if (!cap_stop_i) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = ST_HEADER;
            end
          end else begin
            data_cnt_d = data_cnt_q + CNT_W'(1);
          end
        end
        if (cap_stop_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        emit_c = pk_rdy_c;
        if (ad_data_valid_i) begin
          pend_valid_d = 1'b1;
          pend_samp_d  = samp_c;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A word blocked by a full FIFO is dropped but still occupies its frame slot
    if (emit_c) begin
      if (fifo_full_i) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = emit_word_c;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      dec_cnt_q    <= '0;
      decim_q      <= '0;
      sample_idx_q <= '0;
      data_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_samp_q  <= '0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      decim_q      <= decim_d;
      sample_idx_q <= sample_idx_d;
      data_cnt_q   <= data_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_samp_q  <= pend_samp_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_data_o   = wr_data_q;
  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
